// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: fault bit indices, MMIO
// register offsets and the default MMIO base address.
package dmem_pkg;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;
    localparam int FAULT_PROTO    = 2;
    localparam int NUM_FAULTS     = 3;

    localparam logic [31:0] MMIO_OFF_IO_OUT = 32'h0000_0000;
    localparam logic [31:0] MMIO_OFF_CYCLE  = 32'h0000_0004;
    localparam logic [31:0] MMIO_OFF_FAULT  = 32'h0000_0008;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register bank: IO_OUT register, free-running cycle counter and the
// FAULT read / write-one-to-clear path. Used only when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
    import dmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_io,
    input  logic                  sel_cycle,
    input  logic                  sel_fault,
    input  logic                  wr,
    input  logic [31:0]           wdata,
    input  logic [NUM_FAULTS-1:0] fault_status,
    output logic [31:0]           rdata,
    output logic [31:0]           io_out,
    output logic [NUM_FAULTS-1:0] fault_clr
);

    logic [31:0] io_q;
    logic [31:0] cycle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_q    <= '0;
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (sel_io && wr) begin
                io_q <= wdata;
            end
        end
    end

    // Loads see pre-edge register values, including the counter.
    always_comb begin
        rdata = '0;
        if (sel_io) begin
            rdata = io_q;
        end else if (sel_cycle) begin
            rdata = cycle_q;
        end else if (sel_fault) begin
            rdata = {{(32-NUM_FAULTS){1'b0}}, fault_status};
        end
    end

    assign fault_clr = (sel_fault && wr) ? wdata[NUM_FAULTS-1:0] : '0;
    assign io_out    = io_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with combinational loads, posedge stores,
// sticky fault status, and an optional MMIO bank enabled by DMEM_MMIO_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memoryAddress,
    input  logic [31:0] memoryDataWrite,
    input  logic        memoryWrite,
    input  logic        memoryRead,
    output logic [31:0] memoryDataOut,
    output logic        faultFlag,
    output logic [2:0]  faultStatus,
    output logic [31:0] ioPortOut
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int ADDR_W = IDX_W + 2;

    logic [31:0]           mem [DEPTH_WORDS];
    logic [IDX_W-1:0]      idx;
    logic                  access;
    logic                  aligned;
    logic                  in_ram;
    logic                  mmio_hit;
    logic [31:0]           mmio_rdata;
    logic [NUM_FAULTS-1:0] fault_clr;
    logic [NUM_FAULTS-1:0] fault_set;
    logic [NUM_FAULTS-1:0] fault_q;
    logic                  ram_we;

    assign access  = memoryRead || memoryWrite;
    assign aligned = (memoryAddress[1:0] == 2'b00);
    assign in_ram  = (memoryAddress[31:ADDR_W] == '0);
    assign idx     = memoryAddress[ADDR_W-1:2];

`ifdef DMEM_MMIO_EN
    logic sel_io;
    logic sel_cycle;
    logic sel_fault;

    // RAM decode wins should the MMIO window ever be placed inside RAM.
    assign sel_io    = aligned && !in_ram && (memoryAddress == MMIO_BASE + MMIO_OFF_IO_OUT);
    assign sel_cycle = aligned && !in_ram && (memoryAddress == MMIO_BASE + MMIO_OFF_CYCLE);
    assign sel_fault = aligned && !in_ram && (memoryAddress == MMIO_BASE + MMIO_OFF_FAULT);
    assign mmio_hit  = sel_io || sel_cycle || sel_fault;

    dmem_mmio_regs u_mmio (
        .clk          (clk),
        .rst          (rst),
        .sel_io       (sel_io),
        .sel_cycle    (sel_cycle),
        .sel_fault    (sel_fault),
        .wr           (memoryWrite),
        .wdata        (memoryDataWrite),
        .fault_status (fault_q),
        .rdata        (mmio_rdata),
        .io_out       (ioPortOut),
        .fault_clr    (fault_clr)
    );
`else
    logic unused_mmio_base;

    assign unused_mmio_base = ^MMIO_BASE;
    assign mmio_hit         = 1'b0;
    assign mmio_rdata       = '0;
    assign fault_clr        = '0;
    assign ioPortOut        = '0;
`endif

    always_comb begin
        memoryDataOut = '0;
        if (memoryRead && aligned) begin
            if (in_ram) begin
                memoryDataOut = mem[idx];
            end else if (mmio_hit) begin
                memoryDataOut = mmio_rdata;
            end
        end
    end

    always_comb begin
        fault_set                 = '0;
        fault_set[FAULT_MISALIGN] = access && !aligned;
        fault_set[FAULT_RANGE]    = access && aligned && !in_ram && !mmio_hit;
        fault_set[FAULT_PROTO]    = memoryRead && memoryWrite;
    end

    // A fault raised in the same cycle as a W1C clear survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= '0;
        end else begin
            fault_q <= (fault_q & ~fault_clr) | fault_set;
        end
    end

    assign ram_we = memoryWrite && aligned && in_ram && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx] <= memoryDataWrite;
        end
    end

    assign faultStatus = fault_q;
    assign faultFlag   = |fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; MMIO cases are built
// when DMEM_MMIO_EN is defined.
module tb_data_mem_responder;

    localparam int          DEPTH     = 256;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
    localparam logic [31:0] RAM_END   = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memoryAddress   = '0;
    logic [31:0] memoryDataWrite = '0;
    logic        memoryWrite = 1'b0;
    logic        memoryRead  = 1'b0;
    logic [31:0] memoryDataOut;
    logic        faultFlag;
    logic [2:0]  faultStatus;
    logic [31:0] ioPortOut;

    int n_total = 0;
    int n_bad   = 0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (MMIO_BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .memoryAddress   (memoryAddress),
        .memoryDataWrite (memoryDataWrite),
        .memoryWrite     (memoryWrite),
        .memoryRead      (memoryRead),
        .memoryDataOut   (memoryDataOut),
        .faultFlag       (faultFlag),
        .faultStatus     (faultStatus),
        .ioPortOut       (ioPortOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of strobes at the falling edge; outputs settle by return.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memoryRead      = r;
        memoryWrite     = w;
        memoryAddress   = a;
        memoryDataWrite = d;
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        memoryRead  = 1'b0;
        memoryWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] c1, c2;

    initial begin
        // Reset state
        #2;
        check("rst_fault", {29'b0, faultStatus}, 32'h0);
        check("rst_flag", {31'b0, faultFlag}, 32'h0);
        check("rst_dout", memoryDataOut, 32'h0);
        check("rst_io", ioPortOut, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Store then load next cycle
        cyc(1'b0, 1'b1, 32'h10, 32'h1234_5678);
        cyc(1'b1, 1'b0, 32'h10, 32'h0);
        check("ld_10", memoryDataOut, 32'h1234_5678);
        check("ld_10_flag", {31'b0, faultFlag}, 32'h0);
        cyc(1'b0, 1'b0, 32'h10, 32'h0);
        check("noread_dout", memoryDataOut, 32'h0);

        // Read and write in the same cycle
        cyc(1'b0, 1'b1, 32'h20, 32'hAAAA_AAAA);
        cyc(1'b1, 1'b1, 32'h20, 32'h5555_5555);
        check("rw_old_data", memoryDataOut, 32'hAAAA_AAAA);
        check("rw_no_fault_yet", {29'b0, faultStatus}, 32'h0);
        cyc(1'b1, 1'b0, 32'h20, 32'h0);
        check("proto_set", {29'b0, faultStatus}, 32'h4);
        check("rw_new_data", memoryDataOut, 32'h5555_5555);
        check("proto_flag", {31'b0, faultFlag}, 32'h1);

        // Misalignment and range
        do_reset();
        check("rst_clears_proto", {29'b0, faultStatus}, 32'h0);
        cyc(1'b0, 1'b1, 32'h13, 32'hDEAD_BEEF);
        idle();
        check("misalign_set", {29'b0, faultStatus}, 32'h1);
        cyc(1'b1, 1'b0, 32'h10, 32'h0);
        check("misalign_no_store", memoryDataOut, 32'h1234_5678);
        cyc(1'b1, 1'b0, 32'h12, 32'h0);
        check("misalign_ld_zero", memoryDataOut, 32'h0);
        cyc(1'b0, 1'b1, RAM_END - 32'd4, 32'h0BAD_F00D);
        cyc(1'b1, 1'b0, RAM_END - 32'd4, 32'h0);
        check("last_word", memoryDataOut, 32'h0BAD_F00D);
        check("last_word_no_range", {29'b0, faultStatus}, 32'h1);
        cyc(1'b1, 1'b0, RAM_END, 32'h0);
        check("range_ld_zero", memoryDataOut, 32'h0);
        idle();
        check("range_set", {29'b0, faultStatus}, 32'h3);
        cyc(1'b0, 1'b0, 32'h0000_0007, 32'h0);
        idle();
        check("no_access_no_fault", {29'b0, faultStatus}, 32'h3);

`ifdef DMEM_MMIO_EN
        // Cycle counter and IO_OUT
        cyc(1'b1, 1'b0, MMIO_BASE + 32'h4, 32'h0);
        c1 = memoryDataOut;
        cyc(1'b1, 1'b0, MMIO_BASE + 32'h4, 32'h0);
        c2 = memoryDataOut;
        check("cycle_step", c2 - c1, 32'h1);
        cyc(1'b0, 1'b1, MMIO_BASE + 32'h4, 32'h1234);
        cyc(1'b1, 1'b0, MMIO_BASE + 32'h8, 32'h0);
        check("cycle_store_no_fault", memoryDataOut, 32'h3);
        cyc(1'b0, 1'b1, MMIO_BASE, 32'h0000_CAFE);
        cyc(1'b1, 1'b0, MMIO_BASE, 32'h0);
        check("io_out_port", ioPortOut, 32'h0000_CAFE);
        check("io_out_load", memoryDataOut, 32'h0000_CAFE);

        // FAULT write-one-to-clear
        cyc(1'b0, 1'b1, MMIO_BASE + 32'h8, 32'h1);
        idle();
        check("w1c_misalign", {29'b0, faultStatus}, 32'h2);
        cyc(1'b0, 1'b1, MMIO_BASE + 32'h8, 32'h2);
        idle();
        check("w1c_range", {29'b0, faultStatus}, 32'h0);
        check("w1c_flag", {31'b0, faultFlag}, 32'h0);
        cyc(1'b0, 1'b1, 32'h22, 32'h0);
        cyc(1'b1, 1'b1, MMIO_BASE + 32'h8, 32'h7);
        idle();
        check("clear_vs_new", {29'b0, faultStatus}, 32'h4);
`else
        cyc(1'b1, 1'b0, MMIO_BASE, 32'h0);
        check("mmio_off_ld_zero", memoryDataOut, 32'h0);
        do_reset();
        cyc(1'b0, 1'b1, MMIO_BASE + 32'h8, 32'h7);
        idle();
        check("mmio_off_range", {29'b0, faultStatus}, 32'h2);
        check("mmio_off_io", ioPortOut, 32'h0);
`endif

        // Reset asserted during a store
        cyc(1'b0, 1'b1, 32'h40, 32'h4040_4040);
`ifdef DMEM_MMIO_EN
        cyc(1'b0, 1'b1, MMIO_BASE, 32'h0000_BEEF);
`endif
        cyc(1'b0, 1'b1, 32'h41, 32'h0);
        idle();
        check("pre_rst_faults", {31'b0, faultFlag}, 32'h1);
        @(negedge clk);
        rst             = 1'b1;
        memoryWrite     = 1'b1;
        memoryAddress   = 32'h40;
        memoryDataWrite = 32'hFFFF_FFFF;
        #1;
        check("async_rst_fault", {29'b0, faultStatus}, 32'h0);
        check("async_rst_flag", {31'b0, faultFlag}, 32'h0);
        check("async_rst_io", ioPortOut, 32'h0);
        @(negedge clk);
        rst         = 1'b0;
        memoryWrite = 1'b0;
        cyc(1'b1, 1'b0, 32'h40, 32'h0);
        check("rst_store_dropped", memoryDataOut, 32'h4040_4040);
        cyc(1'b1, 1'b0, 32'h20, 32'h0);
        check("ram_kept_after_rst", memoryDataOut, 32'h5555_5555);
        idle();
        check("post_rst_faults", {29'b0, faultStatus}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the execute stage's load/store interface. Accepts the byte address, store data, and read/write strobes driven by execute. Returns load data combinationally in the same cycle and commits stores on the rising clock edge. Also holds a sticky fault status register and, when configured in, a small MMIO register bank (output port, free-running cycle counter, fault status).

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit RAM words; power of two, at least 4.
- MMIO_BASE, 32'hFFFF_FF00: base byte address of the MMIO bank (used only with DMEM_MMIO_EN).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- memoryAddress  in  32  byte address from execute.
- memoryDataWrite  in  32  store data.
- memoryWrite  in  1  store strobe.
- memoryRead  in  1  load strobe.
- memoryDataOut  out  32  load data, combinational.
- faultFlag  out  1  OR of the sticky fault bits.
- faultStatus  out  3  sticky faults: [0] MISALIGN, [1] RANGE, [2] PROTO.
- ioPortOut  out  32  MMIO output register; constant 0 without DMEM_MMIO_EN.

## Operation
- Decode:
  - RAM region is byte addresses 0 to DEPTH_WORDS*4-1.
  - RAM word index is memoryAddress[log2(DEPTH_WORDS)+1:2].
  - An access is any cycle with memoryRead or memoryWrite high.
- Alignment: an access with memoryAddress[1:0] != 0 is suppressed. No store occurs, memoryDataOut = 0, and MISALIGN is set.
- Range: an aligned access that hits neither RAM nor an enabled MMIO register is suppressed. memoryDataOut = 0 and RANGE is set.
- Load: memoryDataOut = addressed word whenever memoryRead=1. It is 0 whenever memoryRead=0.
- Store: the addressed word takes memoryDataWrite at the posedge.
- Read-during-write at the same address returns the old (pre-edge) content.
- memoryRead and memoryWrite both high:
  - the store is performed;
  - memoryDataOut shows the old content;
  - PROTO is set.
- Fault bits:
  - They are sticky and set at the posedge following the offending cycle.
  - Several bits may be set in one cycle.
  - They are cleared only by rst, or by the MMIO clear (see Configuration).
- RAM contents are not cleared by reset and are undefined at power-up. Benches preload through stores.
- While rst is high, all stores and fault updates are suppressed.

## Timing
- Load latency is 0 cycles: combinational from memoryAddress and memoryRead to memoryDataOut. Execute samples it into its writeback in the same cycle.
- Store is visible to a load in the cycle after the strobe.
- Reset values:
  - faultStatus = 0 and faultFlag = 0;
  - ioPortOut = 0 and the cycle counter = 0;
  - memoryDataOut follows its combinational rule (0 when memoryRead=0).
- Reset assertion mid-operation clears registers immediately (asynchronous). A store presented in the same cycle is dropped.
- Simultaneous fault-clear write and a new fault in the same cycle: the new fault bit ends up set.

## Configuration
- Macro: DMEM_MMIO_EN.
- Defined: an MMIO bank sits at MMIO_BASE, with all offsets word-aligned.
  - +0x0 IO_OUT (R/W): ioPortOut mirrors it.
  - +0x4 CYCLE (RO): a 32-bit counter that increments every cycle out of reset and wraps 0xFFFF_FFFF to 0. Loads return the pre-edge value. Stores are ignored and set no fault.
  - +0x8 FAULT (R/W1C): loads return {29'b0, faultStatus}. A store clears each bit written as 1.
- Undefined:
  - MMIO addresses are RANGE faults.
  - ioPortOut is tied to 0.
  - Faults clear only on rst.
  - No counter is synthesised.

## Structure
- Shared package dmem_pkg holds:
  - fault bit indices (FAULT_MISALIGN=0, FAULT_RANGE=1, FAULT_PROTO=2);
  - MMIO offsets (IO_OUT=0x0, CYCLE=0x4, FAULT=0x8);
  - the default MMIO_BASE.
- One sub-module, dmem_mmio_regs, contains IO_OUT, the cycle counter and the FAULT read/clear path.
  - It is instantiated only under DMEM_MMIO_EN.
  - The top level owns the RAM array, decode, alignment/range checks and fault set logic.

## Test plan
- Store 0x1234_5678 at 0x10, then load 0x10 next cycle: memoryDataOut = 0x1234_5678 combinationally, and faultFlag stays 0.
- RAM[0x20] = 0xAAAA_AAAA. In one cycle, store 0x5555_5555 at 0x20 with memoryRead=1 and memoryWrite=1:
  - that cycle, memoryDataOut = 0xAAAA_AAAA;
  - next cycle, PROTO = 1;
  - a following load returns 0x5555_5555.
- Store at 0x13: RAM unchanged, MISALIGN = 1 next cycle. Load at DEPTH_WORDS*4: returns 0 and RANGE = 1.
- (DMEM_MMIO_EN) Load CYCLE at two consecutive cycles: values differ by 1. Store 0xCAFE to IO_OUT: ioPortOut = 0xCAFE next cycle.
- (DMEM_MMIO_EN) Set MISALIGN and RANGE, then store 0x1 to FAULT: faultStatus = 3'b010. Store 0x2: faultStatus = 0 and faultFlag = 0.
- Assert rst mid-sequence during a store to 0x40:
  - faults and ioPortOut go to 0 immediately;
  - RAM[0x40] keeps its prior value;
  - the first load after reset returns correct RAM data.
